multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The clock port SHALL be `clk`, input, 1 bit; all state SHALL update on its rising edge.
REQ-002 The reset port SHALL be `reset`, input, 1 bit, asynchronous and active-high; one clock; reset is asynchronous and active-high.
REQ-003 `opcode` SHALL be an input, 6 bits: instruction bits [31:26], driven from the instruction register.
REQ-004 `funct` SHALL be an input, 6 bits: instruction bits [5:0].
REQ-005 `aluControlOut` SHALL be an output, 4 bits: the ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT).
REQ-006 The 1-bit outputs SHALL be `pcWrite`, `pcWriteCond`, `iorD`, `memRead`, `memWrite`, `irWrite`, `memToReg`, `regDst`, `regWrite` and `aluSrcA`.
REQ-007 The 2-bit outputs SHALL be `aluSrcB` (00 reg, 01 const 4, 10 sign-extended imm, 11 imm<<2) and `pcSource` (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 `state` SHALL be an output, 4 bits: the current FSM state, for debug.
REQ-009 `illegal` SHALL be an output, 1 bit: a one-cycle pulse on an unsupported instruction.
REQ-010 `retired` SHALL be an output, 32 bits: the count of completed instructions.

Function
REQ-011 The block SHALL be a Moore FSM; all control outputs except `illegal` and `retired` SHALL be decoded from the `state` register only.
REQ-012 The state encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 SHALL go to FETCH on the next edge.
REQ-013 FETCH SHALL assert memRead=1, irWrite=1, aluSrcA=0, aluSrcB=01, aluControlOut=0010, pcWrite=1 and pcSource=00; its next state SHALL be DECODE.
REQ-014 DECODE SHALL drive aluSrcA=0, aluSrcB=11 and aluControlOut=0010, and SHALL latch `opcode`/`funct` into internal registers at the end of the cycle.
REQ-015 Later states SHALL use only the latched values, so changes on the `opcode`/`funct` inputs after DECODE have no effect.
REQ-016 DECODE transitions SHALL depend on opcode: 0x23/0x2B -> MEMADR, 0x00 -> EXEC, 0x04 -> BRANCH, 0x08 -> ADDIEX, 0x02 -> JUMP, any other value -> FETCH.
REQ-017 For opcode 0x00 in DECODE, a funct outside {0x20, 0x22, 0x24, 0x25, 0x2A} SHALL take DECODE -> FETCH as illegal.
REQ-018 MEMADR SHALL drive aluSrcA=1, aluSrcB=10 and ALU=0010; its next state SHALL be MEMRD for lw (0x23) and MEMWR for sw (0x2B).
REQ-019 MEMRD SHALL drive iorD=1 and memRead=1, then go to MEMWB.
REQ-020 MEMWB SHALL drive regDst=0, memToReg=1 and regWrite=1, then go to FETCH.
REQ-021 MEMWR SHALL drive iorD=1 and memWrite=1, then go to FETCH.
REQ-022 EXEC SHALL drive aluSrcA=1 and aluSrcB=00, with aluControlOut from the latched funct: 0x20->0010, 0x22->0110, 0x24->0000, 0x25->0001, 0x2A->0111. Its next state SHALL be ALUWB.
REQ-023 ALUWB SHALL drive regDst=1, memToReg=0 and regWrite=1, then go to FETCH.
REQ-024 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, ALU=0110, pcWriteCond=1 and pcSource=01, then go to FETCH.
REQ-025 ADDIEX SHALL drive aluSrcA=1, aluSrcB=10 and ALU=0010, then go to ADDIWB.
REQ-026 ADDIWB SHALL drive regDst=0, memToReg=0 and regWrite=1, then go to FETCH.
REQ-027 JUMP SHALL drive pcWrite=1 and pcSource=10, then go to FETCH.
REQ-028 Any output not listed for a state SHALL be 0, and `aluControlOut` SHALL default to 0010.
REQ-029 Instruction latency SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-030 `illegal` SHALL be registered: it is 1 for exactly the FETCH cycle that follows an illegal DECODE, and 0 otherwise.
REQ-031 `retired` SHALL increment by 1, wrapping modulo 2^32, on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
REQ-032 `retired` SHALL NOT increment on illegal transitions or on recovery from codes 12-15.

Reset
REQ-033 Asserting `reset` SHALL immediately force state=FETCH, latched opcode/funct=0, illegal=0 and retired=0, independent of `clk`.
REQ-034 While in reset, the outputs SHALL therefore show the FETCH values: memRead=1, irWrite=1, pcWrite=1, aluSrcB=01, aluControlOut=0010, and all others 0.
REQ-035 Reset asserted mid-instruction, including during MEMWB with regWrite=1, SHALL abort the instruction with no further write strobes and no `retired` increment.
REQ-036 After `reset` deasserts, the first rising edge SHALL move the FSM FETCH -> DECODE.

Verification
REQ-037 Test: lw, opcode=0x23. The state sequence SHALL be 0,1,2,3,4,0, with regWrite=1 and memToReg=1 only in state 4, and retired 0->1.
REQ-038 Test: R-type sub, opcode=0x00, funct=0x22. In EXEC, aluControlOut SHALL be 0110; in ALUWB, regDst=1 and regWrite=1. Test again with funct=0x2A, which SHALL give 0111.
REQ-039 Test: beq, opcode=0x04. The FSM SHALL take 3 cycles, with pcWriteCond=1, aluControlOut=0110 and pcSource=01 in BRANCH only.
REQ-040 Test: opcode=0x3F, then opcode=0x00 with funct=0x03. Each SHALL go DECODE->FETCH, pulse `illegal` for 1 cycle, and leave `retired` unchanged.
REQ-041 Test: change `funct` from 0x20 to 0x24 during EXEC. aluControlOut SHALL stay 0010, taken from the latched value.
REQ-042 Test: assert `reset` asynchronously during MEMWB with retired=5. state SHALL become 0 at once, regWrite SHALL become 0, and retired SHALL become 0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle MIPS-subset datapath
// Decodes datapath strobes from the state register; also flags illegal instructions and counts retirements.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  aluControlOut,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        memToReg,
  output logic        regDst,
  output logic        regWrite,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  pcSource,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] next_state;
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic       decode_illegal;
  logic       retire;

  // State register plus the side registers that must all clear together on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      opcode_q <= 6'h00;
      funct_q  <= 6'h00;
      illegal  <= 1'b0;
      retired  <= 32'd0;
    end else begin
      state   <= next_state;
      illegal <= decode_illegal;
      if (state == DECODE) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (retire)
        retired <= retired + 32'd1;
    end
  end

  always_comb begin
    next_state     = FETCH;
    decode_illegal = 1'b0;
    retire         = 1'b0;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        // Decoding looks at the live inputs; they are captured on this same edge
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE: begin
            case (funct)
              6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: next_state = EXEC;
              default: decode_illegal = 1'b1;
            endcase
          end
          OP_BEQ:  next_state = BRANCH;
          OP_ADDI: next_state = ADDIEX;
          OP_J:    next_state = JUMP;
          default: decode_illegal = 1'b1;
        endcase
      end
      MEMADR: next_state = (opcode_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  next_state = MEMWB;
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    aluControlOut = ALU_ADD;
    pcWrite       = 1'b0;
    pcWriteCond   = 1'b0;
    iorD          = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    irWrite       = 1'b0;
    memToReg      = 1'b0;
    regDst        = 1'b0;
    regWrite      = 1'b0;
    aluSrcA       = 1'b0;
    aluSrcB       = 2'b00;
    pcSource      = 2'b00;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        irWrite = 1'b1;
        aluSrcB = 2'b01;
        pcWrite = 1'b1;
      end
      DECODE: aluSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMRD: begin
        iorD    = 1'b1;
        memRead = 1'b1;
      end
      MEMWB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      MEMWR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      EXEC: begin
        aluSrcA = 1'b1;
        case (funct_q)
          6'h22:   aluControlOut = ALU_SUB;
          6'h24:   aluControlOut = ALU_AND;
          6'h25:   aluControlOut = ALU_OR;
          6'h2A:   aluControlOut = ALU_SLT;
          default: aluControlOut = ALU_ADD;
        endcase
      end
      ALUWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      BRANCH: begin
        aluSrcA       = 1'b1;
        aluControlOut = ALU_SUB;
        pcWriteCond   = 1'b1;
        pcSource      = 2'b01;
      end
      ADDIWB: regWrite = 1'b1;
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [3:0]  aluControlOut;
  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic        memToReg, regDst, regWrite, aluSrcA;
  logic [1:0]  aluSrcB, pcSource;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .aluControlOut(aluControlOut), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSource(pcSource), .state(state), .illegal(illegal),
    .retired(retired)
  );

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,pcSource,alu}
  wire [17:0] ctrl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                      regDst, regWrite, aluSrcA, aluSrcB, pcSource, aluControlOut};
  wire [21:0] obs = {state, ctrl};

  localparam logic [21:0] E_FETCH  = {4'd0,  18'b1001010000_01_00_0010};
  localparam logic [21:0] E_DECODE = {4'd1,  18'b0000000000_11_00_0010};
  localparam logic [21:0] E_MEMADR = {4'd2,  18'b0000000001_10_00_0010};
  localparam logic [21:0] E_MEMRD  = {4'd3,  18'b0011000000_00_00_0010};
  localparam logic [21:0] E_MEMWB  = {4'd4,  18'b0000001010_00_00_0010};
  localparam logic [21:0] E_MEMWR  = {4'd5,  18'b0010100000_00_00_0010};
  localparam logic [21:0] E_SUB    = {4'd6,  18'b0000000001_00_00_0110};
  localparam logic [21:0] E_SLT    = {4'd6,  18'b0000000001_00_00_0111};
  localparam logic [21:0] E_ALUWB  = {4'd7,  18'b0000000110_00_00_0010};
  localparam logic [21:0] E_BRANCH = {4'd8,  18'b0100000001_00_01_0110};
  localparam logic [21:0] E_ADDIEX = {4'd9,  18'b0000000001_10_00_0010};
  localparam logic [21:0] E_ADDIWB = {4'd10, 18'b0000000010_00_00_0010};
  localparam logic [21:0] E_JUMP   = {4'd11, 18'b1000000000_00_10_0010};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_retired = 0;
  logic [21:0] seq [0:5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = OP(6'h02); funct = 6'h00;
    #3;
    n_cmp++; if (obs !== E_FETCH) begin n_bad++; $display("FAIL reset_ctrl: got %h want %h", obs, E_FETCH); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_cmp++; if (retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    n_cmp++; if (state !== 4'd1) begin n_bad++; $display("FAIL reset_first_edge: got %0d want 1", state); end
    step();
    n_cmp++; if (obs !== E_JUMP) begin n_bad++; $display("FAIL reset_jump: got %h want %h", obs, E_JUMP); end
    step();
    exp_retired = 1;
    n_cmp++; if (retired !== exp_retired) begin n_bad++; $display("FAIL reset_jump_retired: got %0d want %0d", retired, exp_retired); end
  endtask

  function automatic logic [5:0] OP(input logic [5:0] v);
    return v;
  endfunction

  // Runs one instruction from FETCH; seq[0..n-1] holds the expected states after each edge
  task automatic test_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input int n, input logic ill);
    logic [31:0] base;
    logic [31:0] want_ret;
    logic        want_ill;
    base = exp_retired;
    n_cmp++; if (obs !== E_FETCH) begin n_bad++; $display("FAIL %s_start: got %h want %h", nm, obs, E_FETCH); end
    opcode = op; funct = fn;
    for (int i = 0; i < n; i++) begin
      step();
      want_ret = (i == n - 1 && !ill) ? base + 32'd1 : base;
      want_ill = (i == n - 1) && ill;
      n_cmp++; if (obs !== seq[i]) begin n_bad++; $display("FAIL %s_step%0d: got %h want %h", nm, i, obs, seq[i]); end
      n_cmp++; if (illegal !== want_ill) begin n_bad++; $display("FAIL %s_illegal%0d: got %b want %b", nm, i, illegal, want_ill); end
      n_cmp++; if (retired !== want_ret) begin n_bad++; $display("FAIL %s_retired%0d: got %0d want %0d", nm, i, retired, want_ret); end
    end
    exp_retired = ill ? base : base + 32'd1;
  endtask

  task automatic test_lw();
    seq = '{E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH, E_FETCH};
    test_instr("lw", 6'h23, 6'h00, 5, 1'b0);
  endtask

  task automatic test_rtype();
    seq = '{E_DECODE, E_SUB, E_ALUWB, E_FETCH, E_FETCH, E_FETCH};
    test_instr("sub", 6'h00, 6'h22, 4, 1'b0);
    seq = '{E_DECODE, E_SLT, E_ALUWB, E_FETCH, E_FETCH, E_FETCH};
    test_instr("slt", 6'h00, 6'h2A, 4, 1'b0);
  endtask

  task automatic test_beq();
    seq = '{E_DECODE, E_BRANCH, E_FETCH, E_FETCH, E_FETCH, E_FETCH};
    test_instr("beq", 6'h04, 6'h00, 3, 1'b0);
  endtask

  task automatic test_illegal();
    seq = '{E_DECODE, E_FETCH, E_FETCH, E_FETCH, E_FETCH, E_FETCH};
    test_instr("ill_op", 6'h3F, 6'h00, 2, 1'b1);
    test_instr("ill_funct", 6'h00, 6'h03, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23; funct = 6'h00;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (obs !== E_MEMWB) begin n_bad++; $display("FAIL rmid_memwb: got %h want %h", obs, E_MEMWB); end
    n_cmp++; if (retired !== 32'd5) begin n_bad++; $display("FAIL rmid_pre_retired: got %0d want 5", retired); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (obs !== E_FETCH) begin n_bad++; $display("FAIL rmid_async: got %h want %h", obs, E_FETCH); end
    n_cmp++; if (regWrite !== 1'b0) begin n_bad++; $display("FAIL rmid_regwrite: got %b want 0", regWrite); end
    n_cmp++; if (retired !== 32'd0) begin n_bad++; $display("FAIL rmid_retired: got %0d want 0", retired); end
    @(negedge clk);
    n_cmp++; if (obs !== E_FETCH) begin n_bad++; $display("FAIL rmid_held: got %h want %h", obs, E_FETCH); end
    reset = 1'b0;
    exp_retired = 0;
    seq = '{E_DECODE, E_JUMP, E_FETCH, E_FETCH, E_FETCH, E_FETCH};
    test_instr("rmid_j", 6'h02, 6'h00, 3, 1'b0);
  endtask

  task automatic test_latched_funct();
    opcode = 6'h00; funct = 6'h20;
    step();
    n_cmp++; if (obs !== E_DECODE) begin n_bad++; $display("FAIL latch_decode: got %h want %h", obs, E_DECODE); end
    step();
    funct = 6'h24; opcode = 6'h3F;
    #1;
    n_cmp++; if (state !== 4'd6) begin n_bad++; $display("FAIL latch_exec_state: got %0d want 6", state); end
    n_cmp++; if (aluControlOut !== 4'b0010) begin n_bad++; $display("FAIL latch_alu: got %b want 0010", aluControlOut); end
    step();
    n_cmp++; if (obs !== E_ALUWB) begin n_bad++; $display("FAIL latch_aluwb: got %h want %h", obs, E_ALUWB); end
    step();
    exp_retired = exp_retired + 32'd1;
    n_cmp++; if (retired !== exp_retired) begin n_bad++; $display("FAIL latch_retired: got %0d want %0d", retired, exp_retired); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL latch_illegal: got %b want 0", illegal); end
  endtask

  task automatic test_back_to_back();
    seq = '{E_DECODE, E_MEMADR, E_MEMWR, E_FETCH, E_FETCH, E_FETCH};
    test_instr("sw", 6'h2B, 6'h00, 4, 1'b0);
    seq = '{E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH, E_FETCH, E_FETCH};
    test_instr("addi", 6'h08, 6'h00, 4, 1'b0);
    seq = '{E_DECODE, E_JUMP, E_FETCH, E_FETCH, E_FETCH, E_FETCH};
    test_instr("j", 6'h02, 6'h00, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_reset_mid();
    test_illegal();
    test_latched_funct();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
